// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1 - N-to-1 valid/ready stream multiplexer with a registered
// one-entry output stage.
//
// Channel selection is either a programmable select register (default build)
// or round-robin arbitration when the macro STREAM_MUX_RR_EN is defined.
//
// Parameters: DATA_W word width, N_CH channel count (2..16),
//             SEL_W = ceil(log2(N_CH)).
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_data         N_CH packed words, channel i at [i*DATA_W +: DATA_W]
//   in_valid        per-channel valid
//   in_ready        per-channel ready, at most one bit high
//   sel, sel_load   fixed-mode channel number and its load strobe
//   out_data        registered output word
//   out_valid       output register holds a word
//   out_ready       consumer accepts the word
//   out_ch          source channel of out_data
module stream_mux_nto1 #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   sel_load,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_ch
);

  logic [N_CH-1:0][DATA_W-1:0] data_arr;
  logic [SEL_W-1:0]            gnt;
  logic                        gnt_vld;
  logic                        can_load;
  logic                        xfer;

  assign data_arr = in_data;
  assign can_load = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] last;
  logic             unused_sel;

  assign unused_sel = ^{sel, sel_load};

  // Walk from the lowest priority (last itself) to the highest (last+1) so
  // the final hit, which overwrites earlier ones, is the nearest valid
  // channel after last.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      if (in_valid[(int'(last) + k) % N_CH]) begin
        gnt     = SEL_W'((int'(last) + k) % N_CH);
        gnt_vld = 1'b1;
      end
    end
  end

  // Pointer only advances on an actual transfer; a stalled grant keeps it.
  always_ff @(posedge clk) begin
    if (rst)       last <= SEL_W'(N_CH - 1);
    else if (xfer) last <= gnt;
  end
`else
  logic [SEL_W-1:0] sel_reg;

  always_ff @(posedge clk) begin
    if (rst)           sel_reg <= '0;
    else if (sel_load) sel_reg <= sel;
  end

  assign gnt     = sel_reg;
  // Unused codes above N_CH-1 simply grant nobody.
  assign gnt_vld = 32'(sel_reg) < N_CH;
`endif

  always_comb begin
    in_ready = '0;
    if (!rst && gnt_vld && can_load) in_ready[gnt] = 1'b1;
  end

  // in_ready[gnt] already folds in gnt_vld, so an out-of-range gnt is masked.
  assign xfer = in_valid[gnt] && in_ready[gnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[gnt];
      out_ch    <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
